// File: rtl/micro_ondas_pkg.sv
// micro_ondas_pkg: shared state encoding, 7-segment table and power limit
package micro_ondas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COOKING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Active-high {g,f,e,d,c,b,a} patterns for digits 0..9
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [3:0] MAX_POWER = 4'd10;

endpackage

// File: rtl/micro_ondas_pwr_if.sv
// micro_ondas_pwr_if: keypad/button/door inputs and display/magnetron outputs (beep only with BEEP_EN)
interface micro_ondas_pwr_if #(
    parameter int ND = 3
);
    logic [9:0]      keypad;
    logic            startn;
    logic            stopn;
    logic            door_closed;
    logic [3:0]      power_lvl;
    logic [7*ND-1:0] segs;
    logic            mag_on;
    logic            done;
    logic [1:0]      state;
`ifdef BEEP_EN
    logic            beep;
`endif

    modport master (
        output keypad, startn, stopn, door_closed, power_lvl,
`ifdef BEEP_EN
        input  beep,
`endif
        input  segs, mag_on, done, state
    );

    modport slave (
        input  keypad, startn, stopn, door_closed, power_lvl,
`ifdef BEEP_EN
        output beep,
`endif
        output segs, mag_on, done, state
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: one BCD digit to an active-high 7-segment pattern, blank for non-BCD codes
module bcd_to_7seg
    import micro_ondas_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] segs
);

    assign segs = (bcd < 4'd10) ? SEG_TAB[bcd] : SEG_BLANK;

endmodule

// File: rtl/micro_ondas_pwr.sv
// micro_ondas_pwr: microwave controller with BCD countdown, pause/resume and slotted power (optional beep via BEEP_EN)
module micro_ondas_pwr
    import micro_ondas_pkg::*;
#(
    parameter int N_MIN_DIGITS = 1,
    parameter int CLK_PER_SEC  = 10
) (
    input  logic              clock,
    input  logic              clearn,
    micro_ondas_pwr_if.slave  bus
);

    localparam int ND       = N_MIN_DIGITS + 2;
    localparam int SLOT_CYC = CLK_PER_SEC / 10;
    localparam int CW       = $clog2(CLK_PER_SEC);

    logic [9:0]    key_r, key_p;
    logic          start_r, start_p, stop_r, stop_p;
    logic          key_ev, start_ev, stop_ev;
    logic [3:0]    key_val;
    logic [3:0]    dig [ND];
    logic [3:0]    dec [ND];
    logic          time_nz, dec_nz, borrow;
    state_t        state_q;
    logic [CW-1:0] cnt;
    logic          tick, enter_done;
    logic [3:0]    slot, pwr, pwr_eff;
    logic          mag;

    assign key_ev     = (key_p == '0) && $onehot(key_r);
    assign start_ev   = start_p && !start_r;
    assign stop_ev    = stop_p && !stop_r;
    assign tick       = cnt == CW'(CLK_PER_SEC - 1);
    assign slot       = 4'(cnt / CW'(SLOT_CYC));
    assign pwr_eff    = (bus.power_lvl == 4'd0 || bus.power_lvl > MAX_POWER) ? MAX_POWER : bus.power_lvl;
    assign enter_done = state_q == COOKING && bus.door_closed && !stop_ev && tick && !dec_nz;

    // Register the raw buttons once and keep the previous sample for edge detection
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            key_r   <= '0;
            key_p   <= '0;
            start_r <= 1'b0;
            start_p <= 1'b0;
            stop_r  <= 1'b0;
            stop_p  <= 1'b0;
        end else begin
            key_r   <= bus.keypad;
            key_p   <= key_r;
            start_r <= bus.startn;
            start_p <= start_r;
            stop_r  <= bus.stopn;
            stop_p  <= stop_r;
        end
    end

    // Encode the one-hot key into its digit value
    always_comb begin
        key_val = '0;
        for (int k = 0; k < 10; k++)
            if (key_r[k]) key_val = 4'(k);
    end

    // One-second decrement with borrow: sec-tens wraps to 5, every other digit to 9
    always_comb begin
        borrow  = 1'b1;
        time_nz = 1'b0;
        dec_nz  = 1'b0;
        for (int i = 0; i < ND; i++) begin
            dec[i]  = !borrow ? dig[i] : (dig[i] != 4'd0) ? dig[i] - 4'd1 : (i == 1) ? 4'd5 : 4'd9;
            borrow  = borrow && dig[i] == 4'd0;
            time_nz = time_nz || dig[i] != 4'd0;
            dec_nz  = dec_nz || dec[i] != 4'd0;
        end
    end

    // Controller FSM with digit register, tick counter, latched power and registered mag_on
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_q <= IDLE;
            dig     <= '{default: '0};
            cnt     <= '0;
            pwr     <= MAX_POWER;
            mag     <= 1'b0;
        end else begin
            mag <= state_q == COOKING && slot < pwr && bus.door_closed;
            case (state_q)
                IDLE: begin
                    if (stop_ev) begin
                        dig <= '{default: '0};
                    end else if (start_ev) begin
                        if (bus.door_closed && time_nz) begin
                            state_q <= COOKING;
                            cnt     <= '0;
                            pwr     <= pwr_eff;
                        end
                    end else if (key_ev) begin
                        for (int i = ND - 1; i > 0; i--) dig[i] <= dig[i-1];
                        dig[0] <= key_val;
                    end
                end
                COOKING: begin
                    if (!bus.door_closed || stop_ev) begin
                        state_q <= PAUSED;
                    end else if (tick) begin
                        cnt <= '0;
                        dig <= dec;
                        if (!dec_nz) state_q <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PAUSED: begin
                    if (stop_ev) begin
                        state_q <= IDLE;
                        dig     <= '{default: '0};
                    end else if (start_ev && bus.door_closed) begin
                        state_q <= COOKING;
                        cnt     <= '0;
                        pwr     <= pwr_eff;
                    end
                end
                DONE: begin
                    if (key_ev) begin
                        state_q <= IDLE;
                        dig     <= '{default: '0};
                        dig[0]  <= key_val;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BEEP_EN
    localparam int BEEP_CYC = 3 * CLK_PER_SEC;
    localparam int BW       = $clog2(BEEP_CYC);

    logic [BW-1:0] beep_cnt;
    logic          beep_q;

    // Beep for three seconds after finishing, silenced early by any user action or door opening
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            beep_q   <= 1'b0;
            beep_cnt <= '0;
        end else if (enter_done) begin
            beep_q   <= 1'b1;
            beep_cnt <= BW'(BEEP_CYC - 1);
        end else if (key_ev || start_ev || stop_ev || !bus.door_closed) begin
            beep_q <= 1'b0;
        end else if (beep_q) begin
            beep_q   <= beep_cnt != '0;
            beep_cnt <= beep_cnt - BW'(1);
        end
    end

    assign bus.beep = beep_q;
`endif

    assign bus.state  = state_q;
    assign bus.done   = state_q == DONE;
    assign bus.mag_on = mag;

    for (genvar g = 0; g < ND; g++) begin : g_seg
        bcd_to_7seg u_seg (
            .bcd  (dig[g]),
            .segs (bus.segs[7*g +: 7])
        );
    end

endmodule

// File: doc/micro_ondas_pwr.md
Name: micro_ondas_pwr

Overview:
Parametrised next-generation microwave controller. Adds configurable minute digits, configurable tick rate, a pause/resume/clear state machine and magnetron power levels (time-slot duty cycle).
Keypad entry shifts BCD digits in; the countdown drives per-digit 7-segment outputs and mag_on.
Sits at top level between the keypad/buttons/door switch and the display/magnetron driver.

Parameters:
N_MIN_DIGITS, 1, number of BCD minute digits (1..3); total digits ND = N_MIN_DIGITS+2
CLK_PER_SEC, 10, clock cycles per countdown second; must be a multiple of 10
SLOT_CYC, CLK_PER_SEC/10, cycles per power slot (derived localparam)

Ports:
clock  in  1  system clock, rising edge
clearn  in  1  asynchronous active-low reset
keypad  in  10  one-hot digit keys, bit k = digit k
startn  in  1  start/resume, active-low
stopn  in  1  pause/clear, active-low
door_closed  in  1  1 = door closed
power_lvl  in  4  power 1..10; 0 or >10 treated as 10
segs  out  7*ND  7-seg per digit, digit 0 (sec ones) in [6:0], active-high {g,f,e,d,c,b,a}
mag_on  out  1  magnetron enable
done  out  1  high in DONE state
state  out  2  IDLE=0, COOKING=1, PAUSED=2, DONE=3

Behaviour:
- clearn low: all digits 0, state IDLE, mag_on 0, done 0, every segs digit 7'b0111111, edge registers cleared.
- keypad, startn and stopn are registered once. Events fire on the registered transition:
  - key event: keypad goes from 0 to exactly one bit set.
  - start/stop event: the line goes 1->0.
  - Multi-hot keypad values are ignored and do not arm a new key event until keypad returns to 0.
- Key event, IDLE: digits shift left one place (digit i <- digit i-1, digit 0 <- key); the top digit is discarded. Sec-tens may hold 6..9; this is legal.
- Key event, DONE: digits cleared, then the key is shifted in; go to IDLE.
- Keys are ignored in COOKING and PAUSED.
- Event priority per cycle: door open > stop > start > key.
- IDLE:
  - start with door_closed=1 and nonzero time -> COOKING.
  - start with time 0 or door open is ignored.
  - stop clears all digits.
- COOKING:
  - Door open or stop -> PAUSED.
  - Tick counter resets to 0 on every entry to COOKING. A tick occurs when the counter reaches CLK_PER_SEC-1, so the first decrement comes CLK_PER_SEC cycles after entry.
  - Decrement: sec_ones>0 -> ones-1. Otherwise ones=9 and sec_tens>0 -> tens-1. Otherwise tens=5 and the borrow propagates through the minute digits.
  - The tick that produces all-zero moves to DONE in the same clock edge.
- PAUSED:
  - start with door_closed=1 -> COOKING; time is preserved, the partial second is discarded.
  - stop -> IDLE with digits cleared.
- DONE: start and stop are ignored; a key event -> IDLE (as above).
- power_lvl is latched on each IDLE/PAUSED->COOKING transition as effective power P.
- Slot counter s = tick counter / SLOT_CYC (0..9).
- mag_on is registered: 1 iff state==COOKING && s<P && door_closed. It has one cycle of latency from the state change.
- Reset mid-cook returns to the reset values immediately; no partial state survives.

Optional Feature:
- Macro BEEP_EN.
- Defined: adds output port beep (1 bit), set on entry to DONE and held for 3*CLK_PER_SEC cycles. It is cleared early by a key event, a start/stop event or the door opening. Reset value 0.
- Undefined: no beep port and no beep counter; the rest of the behaviour is identical.

Decomposition:
- Shared package micro_ondas_pkg holds:
  - state encoding constants (IDLE/COOKING/PAUSED/DONE)
  - the 7-seg pattern table for 0..9
  - the blank pattern 7'b0000000, used for non-BCD values
  - MAX_POWER=10
- One sub-module, bcd_to_7seg: combinational 4-bit BCD in, 7-bit segs out, instantiated ND times in a generate loop.

Test Plan:
- Reset (N_MIN_DIGITS=1, CLK_PER_SEC=10) -> segs = {3{7'b0111111}}, state=0, mag_on=0, done=0.
- Keys 1,3,5 then start, door closed, power 10:
  - digits 1:35; state=1 with mag_on continuous.
  - after 10 cycles 1:34; decrementing 1:00 gives 0:59.
- Keys 0,0,2, power 3, start:
  - mag_on high 3 of every 10 cycles.
  - at cycle 20 state=3, done=1, mag_on=0.
  - key 7 -> state=0, digits 0:07.
- Cooking 0:05: stopn pulse -> PAUSED, digits frozen; startn -> resumes; stopn twice (pause, then clear) -> IDLE, 0:00.
- Cooking 0:05: door_closed=0 -> PAUSED, mag_on=0 next cycle; startn with door open ignored; door closed + startn -> COOKING.
- Time 0:00 + startn -> stays IDLE. keypad=10'b0000000110 -> ignored until back to 0. With BEEP_EN: beep high exactly 30 cycles after DONE.
